clic_irq_scheduler: RTL and testbench
=====================================

# clic_irq_scheduler

Interrupt pending tracker and arbiter for the CLIC. It sits between the raw interrupt source lines and the hart: it holds per-source pending state (edge- or level-triggered), selects the highest-level enabled pending source above the hart threshold, and offers it to the core with a valid/ready claim handshake. Configuration comes from the register adapter outputs, and the pending vector is fed back to the register file.

## Interface
- `N_SOURCE`, 32: number of interrupt sources; must equal `clic_reg_pkg::NumSrc`.
- `INTCTLBITS`, 8: implemented level bits; unimplemented low bits of `intctl_i` are treated as 1.
- `clk_i` in, 1: single clock.
- `rst_ni` in, 1: asynchronous, active-low reset.
- `intr_src_i` in, `N_SOURCE`: raw interrupt lines, active-high.
- `intctl_i` in, 8 x `N_SOURCE`: per-source level/priority.
- `ie_i` in, `N_SOURCE`: per-source enable.
- `le_i` in, `N_SOURCE`: 1 = edge-triggered, 0 = level-triggered.
- `shv_i` in, `N_SOURCE`: selective hardware vectoring flag.
- `sw_set_i` / `sw_clr_i` in, `N_SOURCE`: one-cycle software set/clear pulses for edge pending.
- `mintthresh_i` in, 8: hart interrupt threshold.
- `ip_o` out, `N_SOURCE`: current pending vector, to the register file `ip` field.
- `irq_valid_o` out, 1: interrupt offered.
- `irq_ready_i` in, 1: core claims the offered interrupt.
- `irq_id_o` out, `$clog2(N_SOURCE)`: offered source ID.
- `irq_level_o` out, 8: offered level.
- `irq_shv_o` out, 1: offered source `shv`.

## Operation
- Level mode: `pending[i]` = `src[i]` (sampled source, one register stage). Software pulses and claims are ignored.
- Edge mode: `pending_q[i]` is set on a 0->1 transition of `src[i]` or on `sw_set_i[i]`.
  - It is cleared on `sw_clr_i[i]` or on a claim of ID i.
  - Set wins over clear in the same cycle.
- Candidate: `pending & ie_i`.
- Winner: the maximum `intctl_i` among candidates. On equal levels, the higher ID wins. Winner ID, level, shv and an any-candidate flag are registered (`arb_q`).
- Eligible: `arb_q` valid and `arb_q.level > mintthresh_i`.
- The FSM has three states:
  - IDLE: if eligible, go to OFFER and latch ID, level and shv into the output registers.
  - OFFER: `irq_valid_o` = 1. The outputs stay stable until the handshake.
    - If `irq_ready_i` = 1, the claim fires and the FSM goes to WAIT.
    - Otherwise, if the offered source is no longer pending or enabled, drop valid and go to IDLE (withdraw).
    - There is no preemption by a higher-level source while in OFFER.
  - WAIT: one cycle while the arbitration register flushes the claimed winner, then IDLE.
- Threshold changes during OFFER do not withdraw the offer.

## Timing
- Reset values:
  - all `pending_q`, `ip_o`, `arb_q` = 0;
  - FSM = IDLE;
  - `irq_valid_o` = 0, `irq_id_o` = 0, `irq_level_o` = 0, `irq_shv_o` = 0.
- Latency from `intr_src_i` rising before edge 0:
  - `pending`/`ip_o` updates after edge 0;
  - `arb_q` updates after edge 1;
  - `irq_valid_o` = 1 after edge 2.
- Handshake at edge k (valid & ready):
  - the edge pending clears after k;
  - the FSM is in WAIT during k..k+1 and IDLE during k+1..k+2;
  - the next offer is valid after k+2 at the earliest.
- Back-to-back claims therefore leave `irq_valid_o` low for exactly 2 cycles.
- A new edge on the claimed source in the claim cycle keeps it pending (set wins).
- A withdrawal takes effect the cycle after the loss of pending/enable is visible in `pending`/`ie_i`.
- Asynchronous reset mid-offer drops valid immediately, and all pending state is lost.

## Configuration
- `CLIC_SRC_SYNC_EN`:
  - Defined: `intr_src_i` passes through a 2-flop synchronizer before edge detection and level sampling. All latencies from `intr_src_i` grow by 2 cycles. The synchronizer resets to 0.
  - Undefined: `intr_src_i` is sampled directly by one register (it is assumed synchronous to `clk_i`).

## Structure
- In `clic_reg_pkg`: typedef `clic_arb_t` (valid, id, level, shv) and the constant `ClicIdWidth = $clog2(NumSrc)`.
- Sub-module `clic_max_tree`: a combinational binary max tree over (level, id, shv) with higher-ID tie-break, parameterised on `N_SOURCE`. Its output feeds `arb_q`.

## Test plan
- Edge source 5, `intctl` = 0x80, `ie` = 1, threshold 0: raise src 5 -> valid after 3 edges with id=5, level=0x80; ready for one cycle -> `ip_o[5]` = 0 and valid low for 2 cycles.
- Level source 3 (0x40) and edge source 7 (0x40) both pending: id=7 offered first (tie goes to higher ID); after the claim, id=3 is offered and stays pending until src 3 drops.
- Threshold 0x90 with only a 0x80 candidate: no valid. Lower threshold to 0x7F -> valid 1 cycle later with level 0x80.
- Offer of source 2, then clear `ie_i[2]` without ready: valid drops, next winner offered after IDLE.
- `sw_set_i[9]` pulse on an edge source: offered; same-cycle `sw_clr_i[9]` + `sw_set_i[9]` keeps it pending. Assert `rst_ni` mid-offer: all outputs 0 immediately.
- With `CLIC_SRC_SYNC_EN`: the first scenario yields valid after 5 edges.

Source files
------------

// File: rtl/clic_reg_pkg.sv
// Shared types and constants for the CLIC interrupt scheduler: arbitration record,
// scheduler FSM encoding and the intctl level-mask helper.
package clic_reg_pkg;

    localparam int NumSrc      = 32;
    localparam int ClicIdWidth = $clog2(NumSrc);
    localparam int LevelWidth  = 8;

    typedef struct packed {
        logic                   valid;
        logic [ClicIdWidth-1:0] id;
        logic [LevelWidth-1:0]  level;
        logic                   shv;
    } clic_arb_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_WAIT  = 2'd2
    } clic_state_e;

    // Unimplemented low level bits read as ones so levels compare as the hart sees them.
    function automatic logic [LevelWidth-1:0] clic_eff_level(input logic [LevelWidth-1:0] raw,
                                                           input int unsigned         bits);
        logic [LevelWidth-1:0] res;
        res = raw;
        for (int b = 0; b < LevelWidth; b++) begin
            if (b < LevelWidth - int'(bits)) res[b] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/clic_irq_scheduler_if.sv
// Claim handshake between the interrupt scheduler (master) and the hart (slave).
interface clic_irq_scheduler_if;
    import clic_reg_pkg::*;

    logic                   valid;
    logic                   ready;
    logic [ClicIdWidth-1:0] id;
    logic [LevelWidth-1:0]  level;
    logic                   shv;

    modport master (output valid, output id, output level, output shv, input ready);
    modport slave  (input valid, input id, input level, input shv, output ready);

endinterface

// File: rtl/clic_max_tree.sv
// Combinational binary max tree over (level, id, shv); on equal levels the
// higher-ID subtree wins. Invalid leaves never beat a valid one.
module clic_max_tree
    import clic_reg_pkg::*;
#(
    parameter int N_SOURCE = NumSrc
) (
    input  logic [N_SOURCE-1:0]                 cand_i,
    input  logic [N_SOURCE-1:0][LevelWidth-1:0] level_i,
    input  logic [N_SOURCE-1:0]                 shv_i,
    output clic_arb_t                           max_o
);

    localparam int Depth = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1;
    localparam int NLeaf = 1 << Depth;

    always_comb begin : p_tree
        clic_arb_t node [2*NLeaf-1];
        for (int n = 0; n < 2*NLeaf-1; n++) node[n] = '0;
        for (int i = 0; i < N_SOURCE; i++) begin
            node[NLeaf-1+i].valid = cand_i[i];
            node[NLeaf-1+i].id    = ClicIdWidth'(i);
            node[NLeaf-1+i].level = cand_i[i] ? level_i[i] : '0;
            node[NLeaf-1+i].shv   = cand_i[i] & shv_i[i];
        end
        // Right child always covers the higher IDs, so >= gives the tie-break.
        for (int n = NLeaf-2; n >= 0; n--) begin
            if (node[2*n+2].valid &&
                (!node[2*n+1].valid || node[2*n+2].level >= node[2*n+1].level)) begin
                node[n] = node[2*n+2];
            end else begin
                node[n] = node[2*n+1];
            end
        end
        max_o = node[0];
    end

endmodule

// File: rtl/clic_irq_scheduler.sv
// CLIC pending tracker and arbiter: edge/level pending, max-level arbitration and a
// valid/ready claim FSM. Define CLIC_SRC_SYNC_EN to add a 2-flop source synchronizer.
module clic_irq_scheduler
    import clic_reg_pkg::*;
#(
    parameter int N_SOURCE   = NumSrc,
    parameter int INTCTLBITS = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [N_SOURCE-1:0]                  intr_src_i,
    input  logic [N_SOURCE-1:0][LevelWidth-1:0]  intctl_i,
    input  logic [N_SOURCE-1:0]                  ie_i,
    input  logic [N_SOURCE-1:0]                  le_i,
    input  logic [N_SOURCE-1:0]                  shv_i,
    input  logic [N_SOURCE-1:0]                  sw_set_i,
    input  logic [N_SOURCE-1:0]                  sw_clr_i,
    input  logic [LevelWidth-1:0]                mintthresh_i,
    output logic [N_SOURCE-1:0]                  ip_o,
    clic_irq_scheduler_if.master                 irq
);

    logic [N_SOURCE-1:0] src_in;

`ifdef CLIC_SRC_SYNC_EN
    logic [1:0][N_SOURCE-1:0] sync_d, sync_q;

    always_comb begin
        sync_d = {sync_q[0], intr_src_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= sync_d;
    end

    assign src_in = sync_q[1];
`else
    assign src_in = intr_src_i;
`endif

    logic [N_SOURCE-1:0]        src_d, src_q;
    logic [N_SOURCE-1:0]        edge_pend_d, edge_pend_q;
    logic [N_SOURCE-1:0]        pending, cand, claim_vec;
    logic [N_SOURCE-1:0][LevelWidth-1:0] eff_lvl;
    clic_arb_t                  arb_d, arb_q;
    clic_state_e                state_d, state_q;
    logic [ClicIdWidth-1:0]     out_id_d, out_id_q;
    logic [LevelWidth-1:0]      out_level_d, out_level_q;
    logic                       out_shv_d, out_shv_q;
    logic                       claim, eligible, offer_live;

    assign pending = (le_i & edge_pend_q) | (~le_i & src_q);
    assign cand    = pending & ie_i;
    assign ip_o    = pending;
    assign claim   = (state_q == ST_OFFER) && irq.ready;

    // Set sources are OR-ed in last so a new edge survives a same-cycle clear or claim.
    always_comb begin
        src_d     = src_in;
        claim_vec = '0;
        if (claim) claim_vec[out_id_q] = 1'b1;
        edge_pend_d = (src_in & ~src_q) | sw_set_i | (edge_pend_q & ~(sw_clr_i | claim_vec));
    end

    always_comb begin
        for (int i = 0; i < N_SOURCE; i++) begin
            eff_lvl[i] = clic_eff_level(intctl_i[i], INTCTLBITS);
        end
    end

    clic_max_tree #(
        .N_SOURCE (N_SOURCE)
    ) u_max_tree (
        .cand_i  (cand),
        .level_i (eff_lvl),
        .shv_i   (shv_i),
        .max_o   (arb_d)
    );

    assign eligible   = arb_q.valid && (arb_q.level > mintthresh_i);
    assign offer_live = pending[out_id_q] & ie_i[out_id_q];

    // Offer is held stable until claimed; only loss of pending/enable withdraws it.
    always_comb begin
        state_d     = state_q;
        out_id_d    = out_id_q;
        out_level_d = out_level_q;
        out_shv_d   = out_shv_q;
        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    state_d     = ST_OFFER;
                    out_id_d    = arb_q.id;
                    out_level_d = arb_q.level;
                    out_shv_d   = arb_q.shv;
                end
            end
            ST_OFFER: begin
                if (irq.ready)        state_d = ST_WAIT;
                else if (!offer_live) state_d = ST_IDLE;
            end
            ST_WAIT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q       <= '0;
            edge_pend_q <= '0;
            arb_q       <= '0;
            state_q     <= ST_IDLE;
            out_id_q    <= '0;
            out_level_q <= '0;
            out_shv_q   <= 1'b0;
        end else begin
            src_q       <= src_d;
            edge_pend_q <= edge_pend_d;
            arb_q       <= arb_d;
            state_q     <= state_d;
            out_id_q    <= out_id_d;
            out_level_q <= out_level_d;
            out_shv_q   <= out_shv_d;
        end
    end

    assign irq.valid = (state_q == ST_OFFER);
    assign irq.id    = out_id_q;
    assign irq.level = out_level_q;
    assign irq.shv   = out_shv_q;

endmodule

// File: tb/tb_clic_irq_scheduler.sv
// Randomized and directed bench for clic_irq_scheduler against a cycle-level reference model.
`timescale 1ns/1ps
module tb_clic_irq_scheduler;
    import clic_reg_pkg::*;

    localparam int N = 32;
`ifdef CLIC_SRC_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         src, ie, le, shv, sw_set, sw_clr, ip;
    logic [N-1:0][7:0]    intctl;
    logic [7:0]           thresh;

    clic_irq_scheduler_if bus();

    clic_irq_scheduler #(.N_SOURCE(N), .INTCTLBITS(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .intr_src_i   (src),
        .intctl_i     (intctl),
        .ie_i         (ie),
        .le_i         (le),
        .shv_i        (shv),
        .sw_set_i     (sw_set),
        .sw_clr_i     (sw_clr),
        .mintthresh_i (thresh),
        .ip_o         (ip),
        .irq          (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: sampled sources, edge pending, registered winner, offer.
    logic [N-1:0] m_src, m_edge, m_s1, m_s2;
    logic         m_av, m_ashv, m_oshv;
    logic [4:0]   m_aid, m_oid;
    logic [7:0]   m_alvl, m_olvl;
    int           m_st;   // 0 idle, 1 offer, 2 wait

    task automatic model_clear();
        m_src = '0; m_edge = '0; m_s1 = '0; m_s2 = '0;
        m_av = 0; m_ashv = 0; m_oshv = 0; m_aid = '0; m_oid = '0;
        m_alvl = '0; m_olvl = '0; m_st = 0;
    endtask

    task automatic tick();
        logic [N-1:0] pend, s_in, n_edge, s_now, exp_ip;
        logic         claim, found, n_ashv, n_oshv;
        logic [4:0]   n_aid, n_oid;
        logic [7:0]   best, n_olvl;
        int           n_st;
        logic         exp_v;
        s_now = src;
        for (int i = 0; i < N; i++) pend[i] = le[i] ? m_edge[i] : m_src[i];
`ifdef CLIC_SRC_SYNC_EN
        s_in = m_s2;
`else
        s_in = src;
`endif
        claim  = (m_st == 1) && bus.ready;
        n_edge = m_edge;
        for (int i = 0; i < N; i++) begin
            if ((s_in[i] && !m_src[i]) || sw_set[i]) n_edge[i] = 1'b1;
            else if (sw_clr[i] || (claim && m_oid == 5'(i))) n_edge[i] = 1'b0;
        end
        found = 0; best = '0; n_aid = '0; n_ashv = 0;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && ie[i] && (!found || intctl[i] >= best)) begin
                found = 1; best = intctl[i]; n_aid = 5'(i); n_ashv = shv[i];
            end
        end
        n_st = m_st; n_oid = m_oid; n_olvl = m_olvl; n_oshv = m_oshv;
        case (m_st)
            0: if (m_av && m_alvl > thresh) begin
                   n_st = 1; n_oid = m_aid; n_olvl = m_alvl; n_oshv = m_ashv;
               end
            1: if (bus.ready) n_st = 2;
               else if (!(pend[m_oid] && ie[m_oid])) n_st = 0;
            default: n_st = 0;
        endcase
        @(posedge clk); #1;
        m_s2 = m_s1; m_s1 = s_now; m_src = s_in; m_edge = n_edge;
        m_av = found; m_alvl = best; m_aid = n_aid; m_ashv = n_ashv;
        m_st = n_st; m_oid = n_oid; m_olvl = n_olvl; m_oshv = n_oshv;
        for (int i = 0; i < N; i++) exp_ip[i] = le[i] ? m_edge[i] : m_src[i];
        exp_v = (m_st == 1);
        vectors++;
        if (ip !== exp_ip) begin
            miscompares++;
            $display("FAIL model_ip t=%0t: got %h expected %h", $time, ip, exp_ip);
        end
        vectors++;
        if (bus.valid !== exp_v || bus.id !== m_oid || bus.level !== m_olvl || bus.shv !== m_oshv) begin
            miscompares++;
            $display("FAIL model_offer t=%0t: got v=%b id=%0d lvl=%h shv=%b expected v=%b id=%0d lvl=%h shv=%b",
                     $time, bus.valid, bus.id, bus.level, bus.shv, exp_v, m_oid, m_olvl, m_oshv);
        end
    endtask

    task automatic do_reset();
        src = '0; ie = '0; le = '0; shv = '0; sw_set = '0; sw_clr = '0;
        intctl = '0; thresh = '0; bus.ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 0;
        for (int c = 0; c < limit; c++) begin
            if (bus.valid === 1'b1) begin ok = 1; break; end
            tick();
        end
        if (bus.valid === 1'b1) ok = 1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.valid !== 1'b0 || bus.id !== 5'd0 || bus.level !== 8'h00 || bus.shv !== 1'b0 || ip !== '0) begin
            miscompares++;
            $display("FAIL reset: got v=%b id=%0d lvl=%h shv=%b ip=%h expected all zero",
                     bus.valid, bus.id, bus.level, bus.shv, ip);
        end
    endtask

    task automatic test_edge_basic();
        do_reset();
        le[5] = 1; intctl[5] = 8'h80; ie[5] = 1;
        src[5] = 1;
        repeat (2 + SL) tick();
        vectors++;
        if (bus.valid !== 1'b0) begin
            miscompares++; $display("FAIL edge_early_valid: got %b expected 0", bus.valid);
        end
        tick();
        vectors++;
        if (bus.valid !== 1'b1 || bus.id !== 5'd5 || bus.level !== 8'h80) begin
            miscompares++;
            $display("FAIL edge_offer: got v=%b id=%0d lvl=%h expected v=1 id=5 lvl=80", bus.valid, bus.id, bus.level);
        end
        bus.ready = 1; tick(); bus.ready = 0;
        vectors++;
        if (ip[5] !== 1'b0 || bus.valid !== 1'b0) begin
            miscompares++; $display("FAIL edge_claim: got ip5=%b v=%b expected 0 0", ip[5], bus.valid);
        end
        tick();
        vectors++;
        if (bus.valid !== 1'b0) begin
            miscompares++; $display("FAIL edge_gap2: got %b expected 0", bus.valid);
        end
    endtask

    task automatic test_tie();
        bit ok;
        do_reset();
        le[7] = 1; intctl[3] = 8'h40; intctl[7] = 8'h40; ie[3] = 1; ie[7] = 1;
        src[3] = 1; src[7] = 1;
        wait_valid(12, ok);
        vectors++;
        if (!ok || bus.id !== 5'd7) begin
            miscompares++; $display("FAIL tie_first: got ok=%b id=%0d expected id=7", ok, bus.id);
        end
        bus.ready = 1; tick(); bus.ready = 0;
        vectors++;
        if (ip[7] !== 1'b0 || ip[3] !== 1'b1) begin
            miscompares++; $display("FAIL tie_claim_ip: got ip7=%b ip3=%b expected 0 1", ip[7], ip[3]);
        end
        wait_valid(12, ok);
        vectors++;
        if (!ok || bus.id !== 5'd3 || bus.level !== 8'h40) begin
            miscompares++; $display("FAIL tie_second: got ok=%b id=%0d lvl=%h expected id=3 lvl=40", ok, bus.id, bus.level);
        end
        src[3] = 0;
        repeat (1 + SL) tick();
        vectors++;
        if (ip[3] !== 1'b0) begin
            miscompares++; $display("FAIL level_drop: got ip3=%b expected 0", ip[3]);
        end
        tick();
        vectors++;
        if (bus.valid !== 1'b0) begin
            miscompares++; $display("FAIL level_withdraw: got v=%b expected 0", bus.valid);
        end
    endtask

    task automatic test_threshold();
        do_reset();
        le[5] = 1; intctl[5] = 8'h80; ie[5] = 1; thresh = 8'h90;
        src[5] = 1;
        repeat (6) tick();
        vectors++;
        if (bus.valid !== 1'b0) begin
            miscompares++; $display("FAIL thresh_block: got v=%b expected 0", bus.valid);
        end
        thresh = 8'h7F;
        tick();
        vectors++;
        if (bus.valid !== 1'b1 || bus.level !== 8'h80) begin
            miscompares++; $display("FAIL thresh_lower: got v=%b lvl=%h expected v=1 lvl=80", bus.valid, bus.level);
        end
        thresh = 8'hFF;
        tick();
        vectors++;
        if (bus.valid !== 1'b1) begin
            miscompares++; $display("FAIL thresh_no_withdraw: got v=%b expected 1", bus.valid);
        end
        bus.ready = 1; tick(); bus.ready = 0;
    endtask

    task automatic test_withdraw();
        bit ok;
        do_reset();
        le[2] = 1; le[4] = 1; intctl[2] = 8'h60; intctl[4] = 8'h20; ie[2] = 1; ie[4] = 1;
        src[2] = 1; src[4] = 1;
        wait_valid(12, ok);
        vectors++;
        if (!ok || bus.id !== 5'd2) begin
            miscompares++; $display("FAIL wd_first: got ok=%b id=%0d expected id=2", ok, bus.id);
        end
        ie[2] = 0;
        tick();
        vectors++;
        if (bus.valid !== 1'b0) begin
            miscompares++; $display("FAIL wd_drop: got v=%b expected 0", bus.valid);
        end
        tick();
        vectors++;
        if (bus.valid !== 1'b1 || bus.id !== 5'd4 || bus.level !== 8'h20) begin
            miscompares++; $display("FAIL wd_next: got v=%b id=%0d lvl=%h expected v=1 id=4 lvl=20", bus.valid, bus.id, bus.level);
        end
    endtask

    task automatic test_sw_set();
        bit ok;
        do_reset();
        le[9] = 1; intctl[9] = 8'hA0; ie[9] = 1; shv[9] = 1;
        sw_set[9] = 1; tick(); sw_set = '0;
        vectors++;
        if (ip[9] !== 1'b1) begin
            miscompares++; $display("FAIL sw_set_ip: got %b expected 1", ip[9]);
        end
        wait_valid(8, ok);
        vectors++;
        if (!ok || bus.id !== 5'd9 || bus.shv !== 1'b1) begin
            miscompares++; $display("FAIL sw_offer: got ok=%b id=%0d shv=%b expected id=9 shv=1", ok, bus.id, bus.shv);
        end
        sw_set[9] = 1; sw_clr[9] = 1; tick(); sw_set = '0; sw_clr = '0;
        vectors++;
        if (ip[9] !== 1'b1 || bus.valid !== 1'b1) begin
            miscompares++; $display("FAIL set_wins: got ip9=%b v=%b expected 1 1", ip[9], bus.valid);
        end
        sw_clr[9] = 1; tick(); sw_clr = '0;
        vectors++;
        if (ip[9] !== 1'b0 || bus.valid !== 1'b1) begin
            miscompares++; $display("FAIL sw_clr: got ip9=%b v=%b expected 0 1", ip[9], bus.valid);
        end
        tick();
        vectors++;
        if (bus.valid !== 1'b0) begin
            miscompares++; $display("FAIL sw_withdraw: got v=%b expected 0", bus.valid);
        end
        sw_set[9] = 1; tick(); sw_set = '0;
        wait_valid(8, ok);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (!ok || bus.valid !== 1'b0 || bus.id !== 5'd0 || bus.level !== 8'h00 || bus.shv !== 1'b0 || ip !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got ok=%b v=%b id=%0d lvl=%h shv=%b ip=%h expected offer then all zero",
                     ok, bus.valid, bus.id, bus.level, bus.shv, ip);
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        le[5] = 1; intctl[5] = 8'h80; ie[5] = 1;
        sw_set[5] = 1; tick(); sw_set = '0;
        wait_valid(8, ok);
        bus.ready = 1; sw_set[5] = 1; tick(); bus.ready = 0; sw_set = '0;
        vectors++;
        if (!ok || ip[5] !== 1'b1 || bus.valid !== 1'b0) begin
            miscompares++; $display("FAIL claim_set: got ok=%b ip5=%b v=%b expected 1 1 0", ok, ip[5], bus.valid);
        end
        tick();
        vectors++;
        if (bus.valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_gap: got v=%b expected 0", bus.valid);
        end
        tick();
        vectors++;
        if (bus.valid !== 1'b1 || bus.id !== 5'd5) begin
            miscompares++; $display("FAIL b2b_reoffer: got v=%b id=%0d expected v=1 id=5", bus.valid, bus.id);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < N; i++) begin
            le[i]     = 1'($urandom_range(0, 1));
            intctl[i] = 8'($urandom);
            ie[i]     = ($urandom_range(0, 3) != 0);
            shv[i]    = 1'($urandom_range(0, 1));
        end
        thresh = 8'($urandom_range(0, 100));
        for (int c = 0; c < 3000; c++) begin
            src       = src ^ ($urandom & $urandom & $urandom);
            sw_set    = (c % 7 == 0) ? N'($urandom & $urandom & $urandom) : '0;
            sw_clr    = (c % 5 == 0) ? N'($urandom & $urandom) : '0;
            bus.ready = ($urandom_range(0, 3) == 0);
            if (c % 50 == 0)  ie = ie ^ (N'(1) << $urandom_range(0, N-1));
            if (c % 200 == 0) thresh = 8'($urandom_range(0, 200));
            tick();
        end
        sw_set = '0; sw_clr = '0; bus.ready = 0;
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_tie();
        test_threshold();
        test_withdraw();
        test_sw_set();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
